// File: rtl/iter_cell_pkg.sv
// ============================================================================
// iter_cell_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the bit-serial iterative comparison cell chain.
//
//   fsm_state_t : sequencer control states IDLE -> RUN -> DONE -> IDLE
//   MODE_*      : function select {A,B}
//                   MODE_EQ  f = (X == Y)
//                   MODE_GT  f = (X >  Y)
//                   MODE_LT  f = (X <  Y)
//                   MODE_NE  f = (X != Y)
//   ST_*        : 2-bit inter-cell state {gt,lt}. ST_EQ means "no differing
//                 bit seen yet"; {1,1} is never produced by the typical cell.
// ============================================================================
package iter_cell_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    localparam logic [1:0] MODE_EQ = 2'b00;
    localparam logic [1:0] MODE_GT = 2'b01;
    localparam logic [1:0] MODE_LT = 2'b10;
    localparam logic [1:0] MODE_NE = 2'b11;

    localparam logic [1:0] ST_EQ = 2'b00;
    localparam logic [1:0] ST_GT = 2'b10;
    localparam logic [1:0] ST_LT = 2'b01;

endpackage : iter_cell_pkg

// File: rtl/iter_cell_step.sv
// ============================================================================
// iter_cell_step
// ----------------------------------------------------------------------------
// Typical cell of the left-to-right comparison chain (purely combinational).
// While no difference has been seen (state_in == ST_EQ) the cell looks at
// the current bit pair; once a difference has been recorded the decision is
// final, because the most significant differing bit decides the ordering.
//
// Ports:
//   x         in   1  operand X bit at the current position
//   y         in   1  operand Y bit at the current position
//   state_in  in   2  incoming cell state {gt,lt}
//   state_out out  2  outgoing cell state {gt,lt}
// ============================================================================
module iter_cell_step
    import iter_cell_pkg::*;
(
    input  logic       x,
    input  logic       y,
    input  logic [1:0] state_in,
    output logic [1:0] state_out
);

    always_comb begin
        state_out = state_in;
        if (state_in == ST_EQ) begin
            state_out = {x & ~y, ~x & y};
        end
    end

endmodule : iter_cell_step

// File: rtl/iter_cell_sequencer.sv
// ============================================================================
// iter_cell_sequencer
// ----------------------------------------------------------------------------
// Bit-serial sequencer for the iterative comparison cell chain. Captures two
// WIDTH-bit unsigned operands and a function select, walks the typical cell
// over the operands MSB first (one bit per clock), then presents the final
// cell result f through a valid/ack handshake.
//
// Compile-time option:
//   ITER_CELL_SEQ_EARLY_EXIT_EN  when defined, RUN ends on the same edge the
//                                cell state first leaves ST_EQ; the result
//                                is unchanged, only the latency shrinks.
//                                Undefined: all WIDTH bits are always walked.
//
// Parameters:
//   WIDTH   operand width in bits (>= 2)
//
// Ports:
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous active-high reset
//   start  in   1      request, only honoured while ready=1
//   A      in   1      function select, high bit
//   B      in   1      function select, low bit
//   X      in   WIDTH  operand X, captured on accepted start
//   Y      in   WIDTH  operand Y, captured on accepted start
//   ready  out  1      IDLE, can accept start
//   busy   out  1      RUN, evaluation in progress
//   valid  out  1      DONE, f is valid
//   ack    in   1      consumer takes the result, only honoured while valid=1
//   f      out  1      result (0 unless valid=1)
// ============================================================================
module iter_cell_sequencer
    import iter_cell_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             A,
    input  logic             B,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    input  logic             ack,
    output logic             f
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    fsm_state_t       fsm_reg;
    fsm_state_t       fsm_next;

    logic [WIDTH-1:0] x_reg;
    logic [WIDTH-1:0] y_reg;
    logic [1:0]       mode_reg;
    logic [1:0]       cell_reg;
    logic [IDX_W-1:0] idx_reg;

    logic [1:0]       cell_step;
    logic             final_f;
    logic             run_last;

    // ------------------------------------------------------------------
    // Typical cell applied to the bit pair selected by the index counter
    // ------------------------------------------------------------------
    iter_cell_step u_step (
        .x         (x_reg[idx_reg]),
        .y         (y_reg[idx_reg]),
        .state_in  (cell_reg),
        .state_out (cell_step)
    );

    // Last RUN cycle: the index reached bit 0, or (with early exit) the
    // decision has just been made and the remaining bits cannot change it.
`ifdef ITER_CELL_SEQ_EARLY_EXIT_EN
    assign run_last = (idx_reg == '0) || (cell_step != ST_EQ);
`else
    assign run_last = (idx_reg == '0);
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_next = fsm_reg;
        unique case (fsm_reg)
            IDLE: begin
                if (start) begin
                    fsm_next = RUN;
                end
            end
            RUN: begin
                if (run_last) begin
                    fsm_next = DONE;
                end
            end
            DONE: begin
                // start in the ack cycle is deliberately not looked at here;
                // a new request is only taken in the following IDLE cycle.
                if (ack) begin
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        valid = 1'b0;
        f     = 1'b0;
        unique case (fsm_reg)
            IDLE: ready = 1'b1;
            RUN:  busy  = 1'b1;
            DONE: begin
                valid = 1'b1;
                f     = final_f;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Final cell: maps the registered chain state and captured mode to f
    // ------------------------------------------------------------------
    always_comb begin
        final_f = 1'b0;
        unique case (mode_reg)
            MODE_EQ: final_f = (cell_reg == ST_EQ);
            MODE_GT: final_f = (cell_reg == ST_GT);
            MODE_LT: final_f = (cell_reg == ST_LT);
            MODE_NE: final_f = (cell_reg != ST_EQ);
            default: final_f = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, chain state and bit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg    <= '0;
            y_reg    <= '0;
            mode_reg <= MODE_EQ;
            cell_reg <= ST_EQ;
            idx_reg  <= '0;
        end else begin
            unique case (fsm_reg)
                IDLE: begin
                    if (start) begin
                        x_reg    <= X;
                        y_reg    <= Y;
                        mode_reg <= {A, B};
                        cell_reg <= ST_EQ;   // initial cell
                        idx_reg  <= IDX_MSB;
                    end
                end
                RUN: begin
                    cell_reg <= cell_step;
                    // Counter stops at zero instead of wrapping.
                    if (idx_reg != '0) begin
                        idx_reg <= idx_reg - IDX_W'(1);
                    end
                end
                default: begin
                    // DONE holds everything so f stays stable until ack.
                end
            endcase
        end
    end

endmodule : iter_cell_sequencer

// File: tb/tb_iter_cell_sequencer.sv
// ============================================================================
// tb_iter_cell_sequencer
// ----------------------------------------------------------------------------
// Directed self-checking bench for iter_cell_sequencer with WIDTH=8.
// Expected results and latencies are hand-computed from the operands; the
// early-exit latencies follow WIDTH-k, k = most significant differing bit.
// ============================================================================
module tb_iter_cell_sequencer;

    localparam int WIDTH = 8;

`ifdef ITER_CELL_SEQ_EARLY_EXIT_EN
    localparam int LAT_80_7F = 1;   // differ at bit 7
    localparam int LAT_10_20 = 3;   // differ at bit 5
    localparam int LAT_C0_3F = 1;   // differ at bit 7
`else
    localparam int LAT_80_7F = 8;
    localparam int LAT_10_20 = 8;
    localparam int LAT_C0_3F = 8;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic             A;
    logic             B;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic             ready;
    logic             busy;
    logic             valid;
    logic             ack;
    logic             f;

    int checks;
    int passes;
    int fails;

    iter_cell_sequencer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .X     (X),
        .Y     (Y),
        .ready (ready),
        .busy  (busy),
        .valid (valid),
        .ack   (ack),
        .f     (f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges after acceptance until valid rises (bounded).
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (valid !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
    endtask

    // Present start with the given operands; returns just after edge E0.
    task automatic issue(input logic a, input logic b, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        A = a; B = b; X = x; Y = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Full transaction: issue, measure latency, check f, acknowledge.
    task automatic run_op(input string tag, input logic a, input logic b,
                          input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic exp_f, input int exp_lat);
        int lat;
        issue(a, b, x, y);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        wait_valid(lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_f"}, 32'(f), 32'(exp_f));
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ready"}, 32'(ready), 32'd1);
        $display("txn %s A=%0b B=%0b X=%02h Y=%02h f=%0b lat=%0d", tag, a, b, x, y, f, lat);
    endtask

    initial begin
        int lat;
        checks = 0; passes = 0; fails = 0;
        rst = 1'b1; start = 1'b0; ack = 1'b0;
        A = 1'b0; B = 1'b0; X = '0; Y = '0;

        // Reset state
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_f",     32'(f),     32'd0);
        rst = 1'b0;
        tick();

        // Basic modes
        run_op("eq_a5",  1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1, 8);
        run_op("gt_80",  1'b0, 1'b1, 8'h80, 8'h7F, 1'b1, LAT_80_7F);
        run_op("lt_03",  1'b1, 1'b0, 8'h03, 8'h02, 1'b0, 8);
        run_op("ne_03",  1'b1, 1'b1, 8'h03, 8'h02, 1'b1, 8);

        // Second start during RUN, operand changes and stray ack are ignored.
        issue(1'b0, 1'b1, 8'h05, 8'h09);          // GT, 05 > 09 is false
        tick();                                  // E1
        tick();                                  // E2
        A = 1'b1; B = 1'b1; X = 8'hFF; Y = 8'h00;
        start = 1'b1;
        ack = 1'b1;
        tick();                                  // E3
        start = 1'b0;
        ack = 1'b0;
        check("ign_busy",  32'(busy),  32'd1);
        check("ign_ready", 32'(ready), 32'd0);
        wait_valid(lat);
        check("ign_valid", 32'(valid), 32'd1);
        check("ign_f",     32'(f),     32'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ign_idle", 32'(ready), 32'd1);
        $display("txn ign first=05/09 gt second=FF/00 ne f=%0b", f);

        // Reset in the middle of RUN
        issue(1'b0, 1'b0, 8'h11, 8'h11);
        tick(); tick(); tick(); tick();          // RUN cycles 1..4
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_ready", 32'(ready), 32'd1);
        check("mrst_busy",  32'(busy),  32'd0);
        check("mrst_valid", 32'(valid), 32'd0);
        check("mrst_f",     32'(f),     32'd0);
        $display("txn midrun_reset ready=%0b busy=%0b", ready, busy);
        run_op("lt_10", 1'b1, 1'b0, 8'h10, 8'h20, 1'b1, LAT_10_20);

        // Hold in DONE, then ack together with start
        issue(1'b0, 1'b1, 8'hC0, 8'h3F);
        wait_valid(lat);
        check("hold_lat", 32'(lat), 32'(LAT_C0_3F));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 32'(valid), 32'd1);
            check("hold_f",     32'(f),     32'd1);
        end
        A = 1'b0; B = 1'b0; X = 8'h01; Y = 8'h02;
        ack = 1'b1;
        start = 1'b1;
        tick();
        ack = 1'b0;
        start = 1'b0;
        check("ackst_ready", 32'(ready), 32'd1);
        check("ackst_busy",  32'(busy),  32'd0);
        tick();
        check("ackst_still_idle", 32'(ready), 32'd1);
        $display("txn hold_ack C0/3F gt ready=%0b", ready);

        // Start accepted in a normal IDLE cycle afterwards
        run_op("eq_00", 1'b0, 1'b0, 8'h00, 8'h01, 1'b0, 8);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_iter_cell_sequencer
